// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction-decode pipeline stage for the 32-bit CPU. Takes
//               MIPS-format instruction words over a valid/ready handshake,
//               splits them into register-bank read addresses, destination,
//               write enable, extended immediate and control flags, and holds
//               the decoded bundle in a single output pipeline register.
//
//               Optional feature (macro DECODE_SCOREBOARD_EN): a 32-entry busy
//               vector that stalls an instruction whose source register still
//               has a write in flight. Without the macro the stage never
//               stalls and wb_valid/wb_reg are ignored.
//
// Ports       : clk, rst_n            clock, async active-low reset
//               in_valid/in_ready     upstream handshake, in_instr payload
//               out_valid/out_ready   downstream handshake
//               rr1, rr2              rs / rt, drive register bank RR1 / RR2
//               wr_reg, regwrite      destination and its write enable
//               alu_src, mem_read, mem_write, branch, illegal  control flags
//               imm, funct            extended immediate, R-type funct
//               wb_valid, wb_reg      writeback retire (scoreboard clear)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  rr1,
    output logic [4:0]  rr2,
    output logic [4:0]  wr_reg,
    output logic        regwrite,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        illegal,
    output logic [31:0] imm,
    output logic [5:0]  funct,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg
);

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_sext, w_zext;
    logic [4:0]  w_wr_reg;
    logic        w_regwrite, w_alu_src, w_mem_read, w_mem_write;
    logic        w_branch, w_illegal;
    logic [31:0] w_imm;
    logic [5:0]  w_funct;
    logic        w_hazard;
    logic        w_accept;
    logic        w_unused_shamt;

    assign w_opcode = in_instr[31:26];
    assign w_rs     = in_instr[25:21];
    assign w_rt     = in_instr[20:16];
    assign w_rd     = in_instr[15:11];
    assign w_sext   = {{16{in_instr[15]}}, in_instr[15:0]};
    assign w_zext   = {16'h0000, in_instr[15:0]};
    // Shift amount is carried to the ALU by later stages, not decoded here.
    assign w_unused_shamt = ^in_instr[10:6];

    always_comb begin
        w_wr_reg    = 5'd0;
        w_regwrite  = 1'b0;
        w_alu_src   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        w_imm       = 32'h0;
        w_funct     = 6'h00;
        case (w_opcode)
            c_op_rtype: begin
                w_wr_reg   = w_rd;
                w_regwrite = 1'b1;
                w_funct    = in_instr[5:0];
            end
            c_op_addi, c_op_slti: begin
                w_wr_reg   = w_rt;
                w_regwrite = 1'b1;
                w_alu_src  = 1'b1;
                w_imm      = w_sext;
            end
            c_op_andi, c_op_ori: begin
                w_wr_reg   = w_rt;
                w_regwrite = 1'b1;
                w_alu_src  = 1'b1;
                w_imm      = w_zext;
            end
            c_op_lw: begin
                w_wr_reg   = w_rt;
                w_regwrite = 1'b1;
                w_alu_src  = 1'b1;
                w_mem_read = 1'b1;
                w_imm      = w_sext;
            end
            c_op_sw: begin
                w_wr_reg    = w_rt;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_imm       = w_sext;
            end
            c_op_beq: begin
                w_wr_reg = w_rt;
                w_branch = 1'b1;
                w_imm    = w_sext;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // $0 is hard-wired; never schedule a write to it.
        if (w_wr_reg == 5'd0) begin
            w_regwrite = 1'b0;
        end
    end

    assign in_ready = (!out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;
    logic        w_use_rt;
    logic        w_rs_hit, w_rt_hit;

    assign w_use_rt = (w_opcode == c_op_rtype) || (w_opcode == c_op_sw) ||
                      (w_opcode == c_op_beq);

    // A writeback retiring the same register this cycle is bypassed, so it
    // does not hold the instruction back.
    assign w_rs_hit = !w_illegal && r_busy[w_rs] &&
                      !(wb_valid && (wb_reg == w_rs));
    assign w_rt_hit = w_use_rt && r_busy[w_rt] &&
                      !(wb_valid && (wb_reg == w_rt));
    assign w_hazard = w_rs_hit || w_rt_hit;

    // Clear first, then set, so a new writer of the retiring register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_reg] = 1'b0;
        end
        if (w_accept && w_regwrite) begin
            w_busy_nxt[w_wr_reg] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 32'h0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end
`else
    logic w_unused_wb;

    assign w_hazard    = 1'b0;
    assign w_unused_wb = wb_valid ^ (^wb_reg);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rr1       <= 5'd0;
            rr2       <= 5'd0;
            wr_reg    <= 5'd0;
            regwrite  <= 1'b0;
            alu_src   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            branch    <= 1'b0;
            illegal   <= 1'b0;
            imm       <= 32'h0;
            funct     <= 6'h00;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            rr1       <= w_rs;
            rr2       <= w_rt;
            wr_reg    <= w_wr_reg;
            regwrite  <= w_regwrite;
            alu_src   <= w_alu_src;
            mem_read  <= w_mem_read;
            mem_write <= w_mem_write;
            branch    <= w_branch;
            illegal   <= w_illegal;
            imm       <= w_imm;
            funct     <= w_funct;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Accepted instructions
//               push their expected bundle into a queue; consumed bundles are
//               popped and compared. Handshake behaviour is checked inline in
//               each scenario task.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr_reg;
        logic        regwrite;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        illegal;
        logic [31:0] imm;
        logic [5:0]  funct;
    } bundle_t;

    typedef struct packed {
        bundle_t b;
        logic    care_wr;
        logic    care_imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  rr1, rr2, wr_reg;
    logic        regwrite, alu_src, mem_read, mem_write, branch, illegal;
    logic [31:0] imm;
    logic [5:0]  funct;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = 5'd0;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr1       (rr1),
        .rr2       (rr2),
        .wr_reg    (wr_reg),
        .regwrite  (regwrite),
        .alu_src   (alu_src),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .branch    (branch),
        .illegal   (illegal),
        .imm       (imm),
        .funct     (funct),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg)
    );

    always #5 clk = ~clk;

    // Reference decode written from the instruction-set table.
    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        e          = '0;
        e.b.rr1    = i[25:21];
        e.b.rr2    = i[20:16];
        e.care_wr  = 1'b1;
        e.care_imm = 1'b1;
        case (i[31:26])
            6'h00: begin
                e.b.wr_reg = i[15:11]; e.b.regwrite = 1'b1;
                e.b.funct = i[5:0]; e.care_imm = 1'b0;
            end
            6'h08, 6'h0A: begin
                e.b.wr_reg = i[20:16]; e.b.regwrite = 1'b1; e.b.alu_src = 1'b1;
                e.b.imm = {{16{i[15]}}, i[15:0]};
            end
            6'h0C, 6'h0D: begin
                e.b.wr_reg = i[20:16]; e.b.regwrite = 1'b1; e.b.alu_src = 1'b1;
                e.b.imm = {16'h0000, i[15:0]};
            end
            6'h23: begin
                e.b.wr_reg = i[20:16]; e.b.regwrite = 1'b1; e.b.alu_src = 1'b1;
                e.b.mem_read = 1'b1; e.b.imm = {{16{i[15]}}, i[15:0]};
            end
            6'h2B: begin
                e.b.wr_reg = i[20:16]; e.b.alu_src = 1'b1; e.b.mem_write = 1'b1;
                e.b.imm = {{16{i[15]}}, i[15:0]};
            end
            6'h04: begin
                e.b.wr_reg = i[20:16]; e.b.branch = 1'b1;
                e.b.imm = {{16{i[15]}}, i[15:0]};
            end
            default: begin
                e.b.illegal = 1'b1; e.care_wr = 1'b0; e.care_imm = 1'b0;
            end
        endcase
        if (e.b.wr_reg == 5'd0) e.b.regwrite = 1'b0;
        return e;
    endfunction

    // Scoreboard: compare every consumed bundle against the queue head.
    always @(negedge clk) begin
        exp_t    e;
        bundle_t a;
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL bundle_unexpected: out_valid=1 consumed, required no bundle pending");
            end else begin
                e = exp_q.pop_front();
                a = {rr1, rr2, wr_reg, regwrite, alu_src, mem_read, mem_write,
                     branch, illegal, imm, funct};
                if (!e.care_wr)  a.wr_reg = e.b.wr_reg;
                if (!e.care_imm) a.imm    = e.b.imm;
                if (a !== e.b) begin
                    n_err++;
                    $display("FAIL bundle: got %h required %h", a, e.b);
                end
            end
        end
    end

    task automatic send(input logic [31:0] instr, output int waits);
        in_valid = 1'b1;
        in_instr = instr;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: instr %h in_ready=0 after %0d cycles, required 1", instr, waits);
        end else begin
            exp_q.push_back(model(instr));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain_busy();
`ifdef DECODE_SCOREBOARD_EN
        for (int r = 1; r < 32; r++) begin
            wb_valid = 1'b1;
            wb_reg   = 5'(r);
            @(posedge clk); #1;
        end
        wb_valid = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h00221820; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, rr1, rr2, wr_reg, regwrite, alu_src, mem_read, mem_write,
                 branch, illegal, imm, funct} !== 60'h0) begin
                n_err++;
                $display("FAIL reset_outputs: cycle %0d out_valid=%b imm=%h rr1=%0d, required all 0",
                         c, out_valid, imm, rr1);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        int w;
        out_ready = 1'b1;
        send(32'h00221820, w);
        n_cmp++;
        if ({out_valid, rr1, rr2, wr_reg, regwrite, funct} !== {1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 6'h20}) begin
            n_err++;
            $display("FAIL add_decode: got v=%b rr1=%0d rr2=%0d wr=%0d rw=%b funct=%h, required 1/1/2/3/1/20",
                     out_valid, rr1, rr2, wr_reg, regwrite, funct);
        end
        drain_busy();
    endtask

    task automatic test_imm();
        int w;
        out_ready = 1'b1;
        send(32'h2025FFFF, w);
        n_cmp++;
        if ({imm, wr_reg, alu_src} !== {32'hFFFFFFFF, 5'd5, 1'b1}) begin
            n_err++;
            $display("FAIL addi_imm: got imm=%h wr=%0d alu_src=%b, required ffffffff/5/1", imm, wr_reg, alu_src);
        end
        send(32'h34068000, w);
        n_cmp++;
        if (imm !== 32'h00008000) begin
            n_err++; $display("FAIL ori_zext: got imm=%h required 00008000", imm);
        end
        send(32'h8C440008, w);
        n_cmp++;
        if ({mem_read, imm} !== {1'b1, 32'h8}) begin
            n_err++; $display("FAIL lw_decode: got mem_read=%b imm=%h required 1/00000008", mem_read, imm);
        end
        drain_busy();
    endtask

    task automatic test_backpressure();
        int w;
        out_ready = 1'b1;
        send(32'h8C440008, w);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h34068000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready, out_valid, rr1, wr_reg, mem_read, imm} !==
                {1'b0, 1'b1, 5'd2, 5'd4, 1'b1, 32'h8}) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d in_ready=%b out_valid=%b rr1=%0d wr=%0d imm=%h, required 0/1/2/4/00000008",
                         c, in_ready, out_valid, rr1, wr_reg, imm);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release_accept: in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back(model(32'h34068000));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, rr2, imm} !== {1'b1, 5'd6, 32'h8000}) begin
            n_err++;
            $display("FAIL bp_next: got v=%b rr2=%0d imm=%h required 1/6/00008000", out_valid, rr2, imm);
        end
        drain_busy();
    endtask

    task automatic test_scoreboard();
        int w;
        out_ready = 1'b1;
        send(32'h2025FFFF, w);
        in_valid = 1'b1;
        in_instr = 32'h00A13820;
`ifdef DECODE_SCOREBOARD_EN
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || (c > 0 && out_valid !== 1'b0)) begin
                n_err++;
                $display("FAIL sb_stall: cycle %0d in_ready=%b out_valid=%b, required 0 and no bubble fill",
                         c, in_ready, out_valid);
            end
        end
        @(posedge clk); #1;
        wb_valid = 1'b1;
        wb_reg   = 5'd5;
`endif
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL sb_accept: in_ready=%b required 1", in_ready);
        end else begin
            exp_q.push_back(model(32'h00A13820));
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, rr1, wr_reg} !== {1'b1, 5'd5, 5'd7}) begin
            n_err++;
            $display("FAIL sb_result: got v=%b rr1=%0d wr=%0d required 1/5/7", out_valid, rr1, wr_reg);
        end
        drain_busy();
    endtask

    task automatic test_illegal();
        int w;
        out_ready = 1'b1;
        send(32'hFC000000, w);
        n_cmp++;
        if ({out_valid, illegal, regwrite, alu_src, mem_read, mem_write, branch} !== 7'b1100000) begin
            n_err++;
            $display("FAIL illegal: got v=%b ill=%b rw=%b flags=%b%b%b%b required 1/1/0/0000",
                     out_valid, illegal, regwrite, alu_src, mem_read, mem_write, branch);
        end
        send(32'h00220020, w);
        n_cmp++;
        if ({wr_reg, regwrite} !== {5'd0, 1'b0}) begin
            n_err++; $display("FAIL reg0_write: got wr=%0d rw=%b required 0/0", wr_reg, regwrite);
        end
        drain_busy();
    endtask

    task automatic test_back_to_back();
        int w;
        int total;
        logic [31:0] prog [4];
        prog[0] = 32'h28A3FFF0;  // slti $3,$5,-16
        prog[1] = 32'h3082F0F0;  // andi $2,$4,0xF0F0
        prog[2] = 32'hACC7FFFC;  // sw   $7,-4($6)
        prog[3] = 32'h1109FFFE;  // beq  $8,$9,-2
        total = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(prog[k], w);
            total += w;
        end
        n_cmp++;
        if (total !== 0) begin
            n_err++; $display("FAIL b2b_throughput: stall cycles %0d required 0", total);
        end
        drain_busy();
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready = 1'b1;
        send(32'h00221820, w);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if ({out_valid, rr1, wr_reg, regwrite} !== 12'h0) begin
            n_err++; $display("FAIL reset_mid: out_valid=%b rr1=%0d wr=%0d required all 0", out_valid, rr1, wr_reg);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        // $3 was marked busy before reset; it must be free now.
        send(32'h00611020, w);
        n_cmp++;
        if (w !== 0) begin
            n_err++; $display("FAIL reset_mid_busy: stall cycles %0d required 0", w);
        end
        drain_busy();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_imm();
        test_backpressure();
        test_scoreboard();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL queue_drain: %0d bundles never produced, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
